// File: rtl/dmux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmux_pkg
// Description : Shared defaults and slice-enable helper for the dmux block.
// Revision    : 1.0 - initial release
// ============================================================================
package dmux_pkg;

  // Default configuration: the classic 1-bit 1:2 demultiplexer.
  localparam int DMUX_WIDTH_DEF = 1;
  localparam int DMUX_NOUT_DEF  = 2;

  // Upper bound on supported slice count; callers truncate to N_OUT.
  localparam int DMUX_NOUT_MAX  = 64;

  // One-hot enable for the slice addressed by sel. An out-of-range or
  // unknown sel matches no slice, so the result falls back to all-zero.
  function automatic logic [DMUX_NOUT_MAX-1:0] dmux_onehot(
    input logic [31:0] sel,
    input int unsigned n_out
  );
    logic [DMUX_NOUT_MAX-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < DMUX_NOUT_MAX; k++) begin
      if ((k < n_out) && (sel == k)) begin
        v[k] = 1'b1;
      end
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmux_decode.sv
`default_nettype none
// ============================================================================
// Module      : dmux_decode
// Description : Converts the slice select into a one-hot slice enable and an
//               out-of-range indication.
// Revision    : 1.0 - initial release
// ============================================================================
module dmux_decode
  import dmux_pkg::*;
#(
  parameter int N_OUT = DMUX_NOUT_DEF,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic [SEL_W-1:0] i_sel,
  output logic [N_OUT-1:0] o_en,
  output logic             o_oor
);

  // A power-of-two slice count covers every sel encoding.
  localparam bit c_POW2 = (N_OUT == (1 << SEL_W));

  // One-hot enable; unmatched select values give an all-zero enable.
  always_comb begin
    o_en = N_OUT'(dmux_onehot(32'(i_sel), N_OUT));
  end

  if (c_POW2) begin : g_pow2
    assign o_oor = 1'b0;
  end else begin : g_npow2
    assign o_oor = (32'(i_sel) >= 32'(N_OUT));
  end

endmodule
`default_nettype wire

// File: rtl/dmux.sv
`default_nettype none
// ============================================================================
// Module      : dmux
// Description : Parameterised 1-to-N_OUT demultiplexer. The selected slice
//               carries `in`, all others are zero. A sticky flag records any
//               out-of-range select.
//               Build option: DMUX_OUT_REG_EN registers `out` (1-cycle
//               latency, async clear); otherwise `out` is combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module dmux
  import dmux_pkg::*;
#(
  parameter  int WIDTH = DMUX_WIDTH_DEF,
  parameter  int N_OUT = DMUX_NOUT_DEF,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in,
  input  logic [SEL_W-1:0]       sel,
  output logic [N_OUT*WIDTH-1:0] out,
  output logic                   sel_err
);

  logic [N_OUT-1:0]       w_en;
  logic                   w_oor;
  logic [N_OUT*WIDTH-1:0] w_out;
  logic                   r_sel_err;

  dmux_decode #(
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) u_decode (
    .i_sel (sel),
    .o_en  (w_en),
    .o_oor (w_oor)
  );

  // Each slice passes `in` only when its enable is set.
  for (genvar k = 0; k < N_OUT; k++) begin : g_slice
    assign w_out[k*WIDTH +: WIDTH] = in & {WIDTH{w_en[k]}};
  end

`ifdef DMUX_OUT_REG_EN
  logic [N_OUT*WIDTH-1:0] r_out;

  // Output register: captures the routed data each edge, clears async.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_out;
    end
  end

  assign out = r_out;
`else
  assign out = w_out;
`endif

  // Sticky error: set by any out-of-range select, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else if (w_oor) begin
      r_sel_err <= 1'b1;
    end
  end

  assign sel_err = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_dmux.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmux
// Description : Self-checking bench for dmux in three configurations:
//               1x2 (default), 8x4 (power of two) and 4x3 (non power of two).
//               Honours DMUX_OUT_REG_EN when the build defines it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmux;

  logic clk;
  logic rst_n;

  // Default 1:2
  logic [0:0]  in2;
  logic [0:0]  sel2;
  logic [1:0]  out2;
  logic        err2;
  // WIDTH=8, N_OUT=4
  logic [7:0]  in4;
  logic [1:0]  sel4;
  logic [31:0] out4;
  logic        err4;
  // WIDTH=4, N_OUT=3
  logic [3:0]  in3;
  logic [1:0]  sel3;
  logic [11:0] out3;
  logic        err3;

  int n_vec;
  int n_err;

  // Reference sticky flags
  bit m_err2, m_err4, m_err3;

  dmux u_d2 (
    .clk(clk), .rst_n(rst_n), .in(in2), .sel(sel2), .out(out2), .sel_err(err2)
  );
  dmux #(.WIDTH(8), .N_OUT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in(in4), .sel(sel4), .out(out4), .sel_err(err4)
  );
  dmux #(.WIDTH(4), .N_OUT(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in(in3), .sel(sel3), .out(out3), .sel_err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: data shifted into the addressed slice, zero when out of range.
  function automatic logic [63:0] ref_out(int w, int n, logic [63:0] din, int s);
    if (s >= n) return 64'd0;
    return din << (s * w);
  endfunction

  // Wait until a freshly applied input is visible on `out`.
  task automatic settle();
`ifdef DMUX_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  // Update reference sticky flags for the select values held at an edge.
  task automatic model_edge();
    if (rst_n) begin
      if (int'(sel2) >= 2) m_err2 = 1'b1;
      if (int'(sel4) >= 4) m_err4 = 1'b1;
      if (int'(sel3) >= 3) m_err3 = 1'b1;
    end
  endtask

  task automatic check_all_outs(input string tag);
    check({tag, "_out2"}, 64'(out2), ref_out(1, 2, 64'(in2), int'(sel2)));
    check({tag, "_out4"}, 64'(out4), ref_out(8, 4, 64'(in4), int'(sel4)));
    check({tag, "_out3"}, 64'(out3), ref_out(4, 3, 64'(in3), int'(sel3)));
  endtask

  task automatic check_all_errs(input string tag);
    check({tag, "_err2"}, 64'(err2), 64'(m_err2));
    check({tag, "_err4"}, 64'(err4), 64'(m_err4));
    check({tag, "_err3"}, 64'(err3), 64'(m_err3));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_err2 = 0; m_err4 = 0; m_err3 = 0;
    rst_n = 1'b0;
    in2 = '0; sel2 = '0; in4 = '0; sel4 = '0; in3 = '0; sel3 = '0;

    // Reset state
    #1;
    check("rst_out2", 64'(out2), 64'd0);
    check("rst_out4", 64'(out4), 64'd0);
    check("rst_out3", 64'(out3), 64'd0);
    check_all_errs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Default 1:2 truth table: {b,a}
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in2  = 1'(i >> 1);
      sel2 = 1'(i);
      settle();
      check($sformatf("tt_in%0d_sel%0d", i >> 1, i & 1), 64'(out2),
            64'((i >> 1) ? ((i & 1) ? 2 : 1) : 0));
    end

    // 8x4 directed
    @(negedge clk);
    in4 = 8'hA5; sel4 = 2'd2;
    settle();
    check("w8_sel2", 64'(out4), 64'h00A5_0000);
    @(negedge clk);
    sel4 = 2'd0;
    settle();
    check("w8_sel0", 64'(out4), 64'h0000_00A5);

    // 4x3 out-of-range select and sticky flag
    @(negedge clk);
    in3 = 4'hF; sel3 = 2'd3;
    settle();
    check("n3_oor_out", 64'(out3), 64'd0);
    @(posedge clk);
    #1;
    check("n3_err_set", 64'(err3), 64'd1);
    @(negedge clk);
    sel3 = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("n3_err_sticky", 64'(err3), 64'd1);
    check("n3_sel0_out", 64'(out3), 64'h00F);
    #2;
    rst_n = 1'b0;
    #1;
    check("n3_err_clr", 64'(err3), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Power-of-two sweep with all-ones data
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      in4 = 8'hFF; sel4 = 2'(s);
      settle();
      check($sformatf("p2_sweep%0d", s), 64'(out4), 64'hFF << (8 * s));
      @(posedge clk);
      #1;
      check($sformatf("p2_err%0d", s), 64'(err4), 64'd0);
    end

`ifdef DMUX_OUT_REG_EN
    // Registered latency and asynchronous clear
    @(negedge clk);
    in2 = 1'b0; sel2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in2 = 1'b1; sel2 = 1'b1;
    #1;
    check("reg_b_before", 64'(out2[1]), 64'd0);
    @(posedge clk);
    #1;
    check("reg_b_after", 64'(out2[1]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reg_async_clr", 64'(out2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Randomised traffic against the reference model
    m_err2 = 0; m_err4 = 0; m_err3 = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_errs("rnd_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int it = 0; it < 150; it++) begin
      @(negedge clk);
      in2  = 1'($urandom);
      sel2 = 1'($urandom);
      in4  = 8'($urandom);
      sel4 = 2'($urandom);
      in3  = 4'($urandom);
      // Keep the non-power-of-two select mostly in range so the flag
      // flips late in the run rather than immediately.
      sel3 = (it > 100) ? 2'($urandom) : 2'($urandom_range(0, 2));
`ifndef DMUX_OUT_REG_EN
      #1;
      check_all_outs("rnd_comb");
`endif
      @(posedge clk);
      model_edge();
      #1;
`ifdef DMUX_OUT_REG_EN
      check_all_outs("rnd_reg");
`endif
      check_all_errs("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
